mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM->WB stage of the MIPS datapath, directly downstream of data memory. Realigns
//  EX/MEM results with the memory's 1-cycle registered read (leDados), extracts and
//  extends sub-word loads, and selects the ALU result or load data. Drives the
//  register-file write port through a WB pipeline register, plus forwarding/hazard taps.
// PARAMETERS
//  DATA_W  32  datapath width; only 32 is supported
//  REG_AW  5   register index width
// PORTS
//  clock       in   1       single clock; all state updates on rising edge
//  reset       in   1       synchronous, active-high
//  stall       in   1       hold stage A, send a bubble into stage B
//  flush       in   1       kill the instruction being captured into stage A
//  validIn     in   1       EX/MEM slot holds a real instruction
//  lMem        in   1       load (same signal that drives data memory)
//  escReg      in   1       instruction writes the register file
//  memParaReg  in   1       1: write back load data; 0: write back aluOut
//  tipoLe      in   3       load type (package constants)
//  ofsByte     in   2       byte offset within the addressed word
//  regDest     in   REG_AW  destination register
//  aluOut      in   DATA_W  ALU result / memory word address
//  leDados     in   DATA_W  data memory read word, valid one cycle after address
//  escRegWB    out  1       register-file write enable
//  regDestWB   out  REG_AW  register-file write index
//  dadoWB      out  DATA_W  register-file write data
//  validWB     out  1       WB slot holds a real instruction
//  erroAlin    out  1       misaligned load retired this cycle (write suppressed)
//  fwdEsc      out  1       stage A holds a forwardable ALU result
//  fwdReg      out  REG_AW  stage A destination
//  fwdDado     out  DATA_W  stage A ALU result
//  loadPend    out  1       stage A holds a load (result not yet forwardable)
// BEHAVIOUR
//  - Reset: every stage-A/B register and every output is 0.
//  - Stage A (alignment): the edge that presents aluOut to memory captures validIn,
//    controls, regDest, ofsByte and aluOut. flush => vA<=0; else stall => hold;
//    else capture. flush wins over stall.
//  - During stall, upstream holds its inputs, so memory re-reads the same word and
//    leDados stays aligned with the held stage A.
//  - Stage B (write-back): vB <= vA & ~stall; other fields load when vA & ~stall.
//    Latency from capture into A to WB outputs: 2 edges. No duplicate retire on stall.
//  - Extraction, big-endian: ofs 0 = bits 31:24. LW word; LH/LHU halfword
//    (ofs 0 -> 31:16, ofs 2 -> 15:0); LB/LBU byte; LH/LB sign-extend; LHU/LBU zero-extend.
//    Reserved tipoLe codes behave as LW.
//  - Misalignment: LW with ofs!=0, LH/LHU with ofs[0]=1 => erroAlin=1 and
//    escRegWB=0 for that retire. validWB stays 1.
//  - dadoWB = memParaReg ? extracted : aluOut.
//  - escRegWB = vB & escReg & (regDestWB!=0) & ~misaligned.
//  - Taps are combinational from stage A:
//    fwdEsc = vA & escRegA & ~memParaRegA & (regDestA!=0); loadPend = vA & memParaRegA.
// STRUCTURE
//  Package mips_pkg: TL_LW=3'b000, TL_LH=001, TL_LHU=010, TL_LB=011, TL_LBU=100;
//  DATA_W/REG_AW defaults. Sub-module load_extract (combinational: word,
//  ofsByte, tipoLe -> data, misaligned). Stage regs and control stay in this module.
// TESTING
//  1 reset high 2 cycles mid-traffic -> all outputs 0 the following cycle.
//  2 LW regDest=8, aluOut=5, leDados=DEADBEEF -> 2 edges later escRegWB=1,
//    regDestWB=8, dadoWB=DEADBEEF.
//  3 word 12F45678: LB ofs1 -> FFFFFFF4; LBU ofs1 -> 000000F4; LH ofs2 -> 00005678;
//    LH ofs0 -> 000012F4.
//  4 LH ofs1 or LW ofs3 -> erroAlin=1, validWB=1, escRegWB=0; next op unaffected.
//  5 stall 2 cycles with a load in A -> validWB=0 for 2 cycles, then exactly one retire;
//    flush+stall on the same edge -> bubble.
//  6 ADD regDest=0 -> escRegWB=0; ADD regDest=9, aluOut=7 -> fwdEsc=1, fwdReg=9,
//    fwdDado=7 one cycle after capture; load in A -> loadPend=1, fwdEsc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths and load-type encodings.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_AW = 5;

    // Load type codes carried on tipoLe; any other code is treated as a word load.
    localparam logic [2:0] TL_LW  = 3'b000;
    localparam logic [2:0] TL_LH  = 3'b001;
    localparam logic [2:0] TL_LHU = 3'b010;
    localparam logic [2:0] TL_LB  = 3'b011;
    localparam logic [2:0] TL_LBU = 3'b100;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bundle: upstream instruction fields, pipeline control,
// memory read data, register-file write port and forwarding taps.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              validIn;
    logic              lMem;
    logic              escReg;
    logic              memParaReg;
    logic [2:0]        tipoLe;
    logic [1:0]        ofsByte;
    logic [REG_AW-1:0] regDest;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] leDados;

    logic              escRegWB;
    logic [REG_AW-1:0] regDestWB;
    logic [DATA_W-1:0] dadoWB;
    logic              validWB;
    logic              erroAlin;
    logic              fwdEsc;
    logic [REG_AW-1:0] fwdReg;
    logic [DATA_W-1:0] fwdDado;
    logic              loadPend;

    // Upstream pipeline / memory side.
    modport master (
        output stall, flush, validIn, lMem, escReg, memParaReg, tipoLe,
               ofsByte, regDest, aluOut, leDados,
        input  escRegWB, regDestWB, dadoWB, validWB, erroAlin,
               fwdEsc, fwdReg, fwdDado, loadPend
    );

    // The MEM->WB stage itself.
    modport slave (
        input  stall, flush, validIn, lMem, escReg, memParaReg, tipoLe,
               ofsByte, regDest, aluOut, leDados,
        output escRegWB, regDestWB, dadoWB, validWB, erroAlin,
               fwdEsc, fwdReg, fwdDado, loadPend
    );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// Big-endian sub-word load extraction with sign/zero extension and
// alignment check. Purely combinational.
module load_extract
    import mips_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_ofs,
    input  logic [2:0]  i_tipo,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 addresses the most significant byte of the word.
    always_comb begin
        case (i_ofs)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
    end

    // Halfword selection only looks at ofs[1]; ofs[0] set is flagged as misaligned.
    assign w_half = i_ofs[1] ? i_word[15:0] : i_word[31:16];

    // Select and extend per load type; reserved codes fall through as LW.
    always_comb begin
        o_data       = i_word;
        o_misaligned = 1'b0;
        case (i_tipo)
            TL_LH: begin
                o_data       = 32'($signed(w_half));
                o_misaligned = i_ofs[0];
            end
            TL_LHU: begin
                o_data       = {16'h0000, w_half};
                o_misaligned = i_ofs[0];
            end
            TL_LB:   o_data = 32'($signed(w_byte));
            TL_LBU:  o_data = {24'h000000, w_byte};
            default: o_misaligned = (i_ofs != 2'd0);
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: stage A (_p0) lines up with the registered data-memory read,
// stage B (_p1) is the write-back register driving the register file.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_AW = MIPS_REG_AW
) (
    input  logic    clock,
    input  logic    reset,
    mem_wb_if.slave bus
);

    // Stage A: instruction whose memory word is arriving on leDados this cycle.
    logic              r_vld_p0;
    logic              r_lmem_p0;
    logic              r_esc_p0;
    logic              r_m2r_p0;
    logic [2:0]        r_tipo_p0;
    logic [1:0]        r_ofs_p0;
    logic [REG_AW-1:0] r_rd_p0;
    logic [DATA_W-1:0] r_alu_p0;

    // Stage B: retiring instruction.
    logic              r_vld_p1;
    logic              r_esc_p1;
    logic              r_mis_p1;
    logic [REG_AW-1:0] r_rd_p1;
    logic [DATA_W-1:0] r_dado_p1;

    logic [31:0]       w_ext_data;
    logic              w_ext_mis;
    logic              w_mis_p0;
    logic [DATA_W-1:0] w_dado_p0;
    logic              w_adv;

    load_extract u_extract (
        .i_word       (bus.leDados),
        .i_ofs        (r_ofs_p0),
        .i_tipo       (r_tipo_p0),
        .o_data       (w_ext_data),
        .o_misaligned (w_ext_mis)
    );

    // Alignment faults only matter for real memory reads, not ALU ops with a ragged address.
    assign w_mis_p0  = r_lmem_p0 & w_ext_mis;
    assign w_dado_p0 = r_m2r_p0 ? w_ext_data : r_alu_p0;
    assign w_adv     = r_vld_p0 & ~bus.stall;

    // Stage A capture: flush kills the slot, stall holds it, otherwise take the new instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_lmem_p0 <= 1'b0;
            r_esc_p0  <= 1'b0;
            r_m2r_p0  <= 1'b0;
            r_tipo_p0 <= '0;
            r_ofs_p0  <= '0;
            r_rd_p0   <= '0;
            r_alu_p0  <= '0;
        end else if (bus.flush) begin
            r_vld_p0  <= 1'b0;
        end else if (!bus.stall) begin
            r_vld_p0  <= bus.validIn;
            r_lmem_p0 <= bus.lMem;
            r_esc_p0  <= bus.escReg;
            r_m2r_p0  <= bus.memParaReg;
            r_tipo_p0 <= bus.tipoLe;
            r_ofs_p0  <= bus.ofsByte;
            r_rd_p0   <= bus.regDest;
            r_alu_p0  <= bus.aluOut;
        end
    end

    // Stage B: advance only when A is not stalled, so a held load retires exactly once.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_esc_p1  <= 1'b0;
            r_mis_p1  <= 1'b0;
            r_rd_p1   <= '0;
            r_dado_p1 <= '0;
        end else begin
            r_vld_p1 <= w_adv;
            if (w_adv) begin
                r_esc_p1  <= r_esc_p0;
                r_mis_p1  <= w_mis_p0;
                r_rd_p1   <= r_rd_p0;
                r_dado_p1 <= w_dado_p0;
            end
        end
    end

    // Write port: $zero is never written and a misaligned load drops its write.
    assign bus.validWB   = r_vld_p1;
    assign bus.escRegWB  = r_vld_p1 & r_esc_p1 & (r_rd_p1 != '0) & ~r_mis_p1;
    assign bus.regDestWB = r_rd_p1;
    assign bus.dadoWB    = r_dado_p1;
    assign bus.erroAlin  = r_vld_p1 & r_mis_p1;

    // Forwarding taps from stage A: ALU results are usable now, load data is not yet.
    assign bus.fwdEsc   = r_vld_p0 & r_esc_p0 & ~r_m2r_p0 & (r_rd_p0 != '0);
    assign bus.fwdReg   = r_rd_p0;
    assign bus.fwdDado  = r_alu_p0;
    assign bus.loadPend = r_vld_p0 & r_m2r_p0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_wb_if #(.DATA_W(32), .REG_AW(5)) bus ();

    mem_wb_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic v, input logic lmem, input logic esc, input logic m2r,
                          input logic [2:0] tipo, input logic [1:0] ofs,
                          input logic [4:0] rd, input logic [31:0] alu);
        bus.validIn    = v;
        bus.lMem       = lmem;
        bus.escReg     = esc;
        bus.memParaReg = m2r;
        bus.tipoLe     = tipo;
        bus.ofsByte    = ofs;
        bus.regDest    = rd;
        bus.aluOut     = alu;
    endtask

    task automatic set_idle();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, TL_LW, 2'd0, 5'd0, 32'h0);
    endtask

    // Load issued on one edge, memory word presented in the following cycle, retired on the next edge.
    task automatic run_load(input logic [2:0] tipo, input logic [1:0] ofs,
                            input logic [4:0] rd, input logic [31:0] word);
        set_op(1'b1, 1'b1, 1'b1, 1'b1, tipo, ofs, rd, 32'h0000_0100 | 32'(ofs));
        tick();
        set_idle();
        bus.leDados = word;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_validWB"},   32'(bus.validWB),   32'h0);
        check_val({tag, "_escRegWB"},  32'(bus.escRegWB),  32'h0);
        check_val({tag, "_regDestWB"}, 32'(bus.regDestWB), 32'h0);
        check_val({tag, "_dadoWB"},    bus.dadoWB,         32'h0);
        check_val({tag, "_erroAlin"},  32'(bus.erroAlin),  32'h0);
        check_val({tag, "_fwdEsc"},    32'(bus.fwdEsc),    32'h0);
        check_val({tag, "_fwdReg"},    32'(bus.fwdReg),    32'h0);
        check_val({tag, "_fwdDado"},   bus.fwdDado,        32'h0);
        check_val({tag, "_loadPend"},  32'(bus.loadPend),  32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.leDados = 32'h0;
        set_idle();

        // Power-on reset
        tick();
        tick();
        check_all_zero("por");
        reset = 1'b0;

        // LW into r8
        run_load(TL_LW, 2'd0, 5'd8, 32'hDEADBEEF);
        check_val("lw_valid", 32'(bus.validWB),   32'h1);
        check_val("lw_esc",   32'(bus.escRegWB),  32'h1);
        check_val("lw_rd",    32'(bus.regDestWB), 32'h8);
        check_val("lw_dado",  bus.dadoWB,         32'hDEADBEEF);
        check_val("lw_err",   32'(bus.erroAlin),  32'h0);

        // Sub-word extraction
        run_load(TL_LB, 2'd1, 5'd3, 32'h12F45678);
        check_val("lb1",  bus.dadoWB, 32'hFFFFFFF4);
        check_val("lb1_err", 32'(bus.erroAlin), 32'h0);
        run_load(TL_LBU, 2'd1, 5'd3, 32'h12F45678);
        check_val("lbu1", bus.dadoWB, 32'h000000F4);
        run_load(TL_LH, 2'd2, 5'd3, 32'h12F45678);
        check_val("lh2",  bus.dadoWB, 32'h00005678);
        run_load(TL_LH, 2'd0, 5'd3, 32'h12F45678);
        check_val("lh0",  bus.dadoWB, 32'h000012F4);
        check_val("lh0_esc", 32'(bus.escRegWB), 32'h1);
        run_load(TL_LB, 2'd3, 5'd3, 32'h12F45678);
        check_val("lb3",  bus.dadoWB, 32'h00000078);
        run_load(TL_LH, 2'd0, 5'd3, 32'h8765ABCD);
        check_val("lh0_neg", bus.dadoWB, 32'hFFFF8765);
        run_load(TL_LHU, 2'd0, 5'd3, 32'h8765ABCD);
        check_val("lhu0", bus.dadoWB, 32'h00008765);
        run_load(TL_LBU, 2'd2, 5'd3, 32'h8765ABCD);
        check_val("lbu2", bus.dadoWB, 32'h000000AB);
        run_load(3'b111, 2'd0, 5'd3, 32'h8765ABCD);
        check_val("rsvd_as_lw", bus.dadoWB, 32'h8765ABCD);

        // Misaligned loads retire without writing
        run_load(TL_LH, 2'd1, 5'd4, 32'h11223344);
        check_val("lh1_err",   32'(bus.erroAlin), 32'h1);
        check_val("lh1_valid", 32'(bus.validWB),  32'h1);
        check_val("lh1_esc",   32'(bus.escRegWB), 32'h0);
        run_load(TL_LW, 2'd3, 5'd4, 32'h11223344);
        check_val("lw3_err",   32'(bus.erroAlin), 32'h1);
        check_val("lw3_valid", 32'(bus.validWB),  32'h1);
        check_val("lw3_esc",   32'(bus.escRegWB), 32'h0);
        run_load(TL_LW, 2'd0, 5'd5, 32'h55667788);
        check_val("after_err_err",  32'(bus.erroAlin), 32'h0);
        check_val("after_err_esc",  32'(bus.escRegWB), 32'h1);
        check_val("after_err_dado", bus.dadoWB,        32'h55667788);

        // Two-cycle stall with a load in stage A
        set_op(1'b1, 1'b1, 1'b1, 1'b1, TL_LW, 2'd0, 5'd10, 32'h200);
        tick();
        set_idle();
        bus.leDados = 32'hCAFEF00D;
        bus.stall = 1'b1;
        tick();
        check_val("stall1_valid", 32'(bus.validWB),  32'h0);
        check_val("stall1_pend",  32'(bus.loadPend), 32'h1);
        tick();
        check_val("stall2_valid", 32'(bus.validWB),  32'h0);
        bus.stall = 1'b0;
        tick();
        check_val("unstall_valid", 32'(bus.validWB),   32'h1);
        check_val("unstall_rd",    32'(bus.regDestWB), 32'hA);
        check_val("unstall_dado",  bus.dadoWB,         32'hCAFEF00D);
        tick();
        check_val("no_dup_valid",  32'(bus.validWB),   32'h0);

        // Flush and stall on the same edge produce a bubble
        set_op(1'b1, 1'b1, 1'b1, 1'b1, TL_LW, 2'd0, 5'd11, 32'h300);
        tick();
        bus.leDados = 32'h0BADF00D;
        set_op(1'b1, 1'b0, 1'b1, 1'b0, TL_LW, 2'd0, 5'd12, 32'h44);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        tick();
        check_val("fs_valid", 32'(bus.validWB),  32'h0);
        check_val("fs_pend",  32'(bus.loadPend), 32'h0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_idle();
        tick();
        check_val("fs_bubble", 32'(bus.validWB), 32'h0);

        // Flush alone kills the instruction being captured
        set_op(1'b1, 1'b0, 1'b1, 1'b0, TL_LW, 2'd0, 5'd13, 32'h66);
        bus.flush = 1'b1;
        tick();
        check_val("flush_fwd", 32'(bus.fwdEsc), 32'h0);
        bus.flush = 1'b0;
        set_idle();
        tick();
        check_val("flush_valid", 32'(bus.validWB), 32'h0);

        // ALU op to $zero never writes
        set_op(1'b1, 1'b0, 1'b1, 1'b0, TL_LW, 2'd1, 5'd0, 32'h55);
        tick();
        check_val("r0_fwd", 32'(bus.fwdEsc), 32'h0);
        set_idle();
        tick();
        check_val("r0_valid", 32'(bus.validWB),  32'h1);
        check_val("r0_esc",   32'(bus.escRegWB), 32'h0);
        check_val("r0_dado",  bus.dadoWB,        32'h55);

        // ALU op forwarding tap; ragged address on a non-load is not a fault
        set_op(1'b1, 1'b0, 1'b1, 1'b0, TL_LW, 2'd3, 5'd9, 32'h7);
        tick();
        check_val("add_fwdEsc",  32'(bus.fwdEsc),   32'h1);
        check_val("add_fwdReg",  32'(bus.fwdReg),   32'h9);
        check_val("add_fwdDado", bus.fwdDado,       32'h7);
        check_val("add_pend",    32'(bus.loadPend), 32'h0);
        set_idle();
        tick();
        check_val("add_esc",  32'(bus.escRegWB),  32'h1);
        check_val("add_rd",   32'(bus.regDestWB), 32'h9);
        check_val("add_dado", bus.dadoWB,         32'h7);
        check_val("add_err",  32'(bus.erroAlin),  32'h0);

        // Load in stage A is pending, not forwardable
        set_op(1'b1, 1'b1, 1'b1, 1'b1, TL_LW, 2'd0, 5'd14, 32'h400);
        tick();
        check_val("ld_pend",   32'(bus.loadPend), 32'h1);
        check_val("ld_fwdEsc", 32'(bus.fwdEsc),   32'h0);

        // Reset mid-traffic
        set_op(1'b1, 1'b0, 1'b1, 1'b0, TL_LW, 2'd0, 5'd15, 32'h99);
        bus.leDados = 32'h12345678;
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        set_idle();
        tick();
        check_val("post_rst_valid", 32'(bus.validWB), 32'h0);
        check_val("post_rst_esc",   32'(bus.escRegWB), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
